i2c_cfg_sequencer: RTL

Power-up configuration sequencer for board I2C peripherals such as the TMDS retimer. It walks a table of register writes and issues each one as a command to a byte-level I2C master through a valid/ready command channel and a response strobe. It handles NACK retries and reports done or error status. A start pulse re-runs the table, for example after HDMI hot-plug.

---
 rtl/i2c_cfg_sequencer.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cfg_sequencer
//
// Power-up configuration sequencer for board I2C peripherals (e.g. the TMDS
// retimer). After an initial delay it walks a table of register writes and
// hands each one to a byte-level I2C master over a valid/ready command
// channel. NACKed writes are retried after a back-off gap. The sequencer ends
// in a done or error state, and a start pulse re-runs the table.
//
// Optional feature macro: I2C_CFG_READBACK_EN
//   When defined, every acknowledged write is followed by a read of the same
//   register. A read NACK or a data mismatch counts as a failed attempt, and
//   the retry restarts from the write.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle pulse; re-runs the table from DONE/FAIL
//   tbl_idx_o    table index presented to the external table
//   tbl_entry_i  {reg[15:8], data[7:0]}, combinational read of tbl_idx_o
//   cmd_valid_o  command valid
//   cmd_ready_i  master accepts the command
//   cmd_dev_o    7-bit slave address (DEV_ADDR while cmd_valid_o is high)
//   cmd_rd_o     1 = register read, 0 = register write
//   cmd_reg_o    register address
//   cmd_wdata_o  write data
//   rsp_valid_i  one-cycle response strobe
//   rsp_nack_i   NACK flag, qualified by rsp_valid_i
//   rsp_rdata_i  read data, qualified by rsp_valid_i
//   busy_o       sequence in progress
//   done_o       all entries written (level)
//   error_o      an entry failed after all retries (level)
//   err_idx_o    index of the failing entry
//
// State       | meaning
// ------------+--------------------------------------------------------------
// ST_DELAY    | post-reset wait of INIT_DELAY cycles
// ST_IDLE     | parked, waiting for start_i (not entered in this variant)
// ST_FETCH    | latch table entry at the current index
// ST_ISSUE    | write command presented, waiting for cmd_ready_i
// ST_WAIT_RSP | waiting for the write response
// ST_BACKOFF  | idle gap after a failed attempt before re-issuing the write
// ST_DONE     | all entries acknowledged
// ST_FAIL     | an entry exhausted its retries
// ST_ISSUE_RD | readback command presented (readback build only)
// ST_WAIT_RD  | waiting for the readback response (readback build only)
// ---------------------------------------------------------------------------
module i2c_cfg_sequencer #(
    parameter int unsigned  NUM_ENTRIES = 4,
    parameter logic [6:0]   DEV_ADDR    = 7'h5D,
    parameter int unsigned  INIT_DELAY  = 5_000_000,
    parameter int unsigned  MAX_RETRY   = 3,
    parameter int unsigned  RETRY_GAP   = 4000,
    localparam int unsigned IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic [IW-1:0] tbl_idx_o,
    input  logic [15:0]   tbl_entry_i,
    output logic          cmd_valid_o,
    input  logic          cmd_ready_i,
    output logic [6:0]    cmd_dev_o,
    output logic          cmd_rd_o,
    output logic [7:0]    cmd_reg_o,
    output logic [7:0]    cmd_wdata_o,
    input  logic          rsp_valid_i,
    input  logic          rsp_nack_i,
    input  logic [7:0]    rsp_rdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [IW-1:0] err_idx_o
);

    localparam int unsigned DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;

    typedef enum logic [3:0] {
        ST_DELAY,
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_BACKOFF,
        ST_DONE,
        ST_FAIL
`ifdef I2C_CFG_READBACK_EN
        ,
        ST_ISSUE_RD,
        ST_WAIT_RD
`endif
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_dly_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [RW-1:0] r_retry;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_err_idx;
    logic          r_cmd_valid;
    logic [7:0]    r_cmd_reg;
    logic [7:0]    r_cmd_wdata;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_last;
    logic          w_can_retry;
    logic          w_dly_tc;

    assign w_last      = (r_idx == IW'(NUM_ENTRIES - 1));
    assign w_can_retry = (r_retry < RW'(MAX_RETRY));
    assign w_dly_tc    = (INIT_DELAY <= 1) || (r_dly_cnt == DW'(INIT_DELAY - 1));

`ifdef I2C_CFG_READBACK_EN
    logic          r_cmd_rd;
    logic [7:0]    r_exp;
    logic          w_rd_ok;

    // Written data is kept in r_exp because cmd_wdata_o is zeroed for reads
    // and must be restored when the write is retried.
    assign w_rd_ok  = !rsp_nack_i && (rsp_rdata_i == r_exp);
    assign cmd_rd_o = r_cmd_rd;
`else
    logic          w_unused_rdata;

    assign w_unused_rdata = ^rsp_rdata_i;
    assign cmd_rd_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_DELAY;
            r_dly_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_retry     <= '0;
            r_idx       <= '0;
            r_err_idx   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_reg   <= '0;
            r_cmd_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef I2C_CFG_READBACK_EN
            r_cmd_rd    <= 1'b0;
            r_exp       <= '0;
`endif
        end else begin
            case (r_state)
                ST_DELAY: begin
                    r_busy <= 1'b1;
                    if (w_dly_tc) begin
                        r_idx   <= '0;
                        r_state <= ST_FETCH;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end

                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_i) begin
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_err_idx <= '0;
                        r_idx     <= '0;
                        r_retry   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    r_cmd_reg   <= tbl_entry_i[15:8];
                    r_cmd_wdata <= tbl_entry_i[7:0];
                    r_cmd_valid <= 1'b1;
`ifdef I2C_CFG_READBACK_EN
                    r_exp       <= tbl_entry_i[7:0];
                    r_cmd_rd    <= 1'b0;
`endif
                    r_state     <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    if (cmd_ready_i) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= ST_WAIT_RSP;
                    end
                end

                ST_WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        if (!rsp_nack_i) begin
`ifdef I2C_CFG_READBACK_EN
                            r_cmd_rd    <= 1'b1;
                            r_cmd_wdata <= '0;
                            r_cmd_valid <= 1'b1;
                            r_state     <= ST_ISSUE_RD;
`else
                            r_retry <= '0;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_DONE;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ST_FETCH;
                            end
`endif
                        end else if (w_can_retry) begin
                            r_retry   <= r_retry + 1'b1;
                            r_gap_cnt <= GW'(RETRY_GAP);
                            r_state   <= ST_BACKOFF;
                        end else begin
                            r_error   <= 1'b1;
                            r_err_idx <= r_idx;
                            r_busy    <= 1'b0;
                            r_state   <= ST_FAIL;
                        end
                    end
                end

`ifdef I2C_CFG_READBACK_EN
                ST_ISSUE_RD: begin
                    if (cmd_ready_i) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= ST_WAIT_RD;
                    end
                end

                ST_WAIT_RD: begin
                    if (rsp_valid_i) begin
                        if (w_rd_ok) begin
                            r_retry <= '0;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_DONE;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ST_FETCH;
                            end
                        end else if (w_can_retry) begin
                            r_retry   <= r_retry + 1'b1;
                            r_gap_cnt <= GW'(RETRY_GAP);
                            r_state   <= ST_BACKOFF;
                        end else begin
                            r_error   <= 1'b1;
                            r_err_idx <= r_idx;
                            r_busy    <= 1'b0;
                            r_state   <= ST_FAIL;
                        end
                    end
                end
`endif

                ST_BACKOFF: begin
                    // Re-issue from the latched command; the table is not
                    // re-read so a changing table cannot alter a retry.
                    if (r_gap_cnt == '0) begin
                        r_cmd_valid <= 1'b1;
`ifdef I2C_CFG_READBACK_EN
                        r_cmd_rd    <= 1'b0;
                        r_cmd_wdata <= r_exp;
`endif
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                default: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= ST_DELAY;
                end
            endcase
        end
    end

    assign tbl_idx_o   = r_idx;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_dev_o   = r_cmd_valid ? DEV_ADDR : 7'h00;
    assign cmd_reg_o   = r_cmd_reg;
    assign cmd_wdata_o = r_cmd_wdata;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign error_o     = r_error;
    assign err_idx_o   = r_err_idx;

endmodule
